// File: rtl/piso_serializer_if.sv
// Parallel-word handshake and serial-side bus of the PISO serializer.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready from the serializer throttles the word producer.
// Ports/modports:
//   slave  - serializer side: sinks in_data/in_valid, drives in_ready and the serial outputs
//   master - producer/observer side: drives in_data/in_valid, sees everything else
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             word_done;
    logic             busy;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial_out,
        output serial_valid,
        output frame_start,
        output word_done,
        output busy
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_start,
        input  word_done,
        input  busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding register for gapless streaming.
// Latency: word accepted at edge N -> first bit in cycle N+1, last bit in cycle N+WIDTH.
// Backpressure: in_ready drops while the holding register is full and during rst.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - piso_serializer_if.slave: word handshake in, serial bit + framing strobes out
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_serializer_if.slave      bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [CW-1:0]    bit_cnt;
    logic             hold_full;

    logic accept;
    logic cur_bit;
    logic shifting;

    assign bus.in_ready = !rst && !hold_full;
    assign accept       = bus.in_valid && bus.in_ready;

    // The output end of shift_reg depends on bit order; the shift below
    // always moves data toward that end.
    assign cur_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shifting = (state == SHIFT);

    // All serial-side outputs come from registered state only, so nothing on
    // in_* can reach the downstream SIPO combinationally.
    assign bus.serial_valid = shifting;
    assign bus.serial_out   = shifting && cur_bit;
    assign bus.frame_start  = shifting && (bit_cnt == '0);
    assign bus.word_done    = shifting && (bit_cnt == LAST_BIT);
    assign bus.busy         = shifting || hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= bus.in_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != LAST_BIT) begin
                        if (MSB_FIRST) begin
                            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        end else begin
                            shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                        end
                        bit_cnt <= bit_cnt + CW'(1);
                        if (accept) begin
                            hold_reg  <= bus.in_data;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // Held word takes over right after the last bit: no gap.
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (accept) begin
                        // Bypass: word arriving on the last-bit cycle with an
                        // empty holding register goes straight into shift_reg.
                        shift_reg <= bus.in_data;
                        bit_cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage that sits directly upstream of the `SIPO` shift register and drives its `serial_in`. It accepts `WIDTH`-bit words over a valid/ready handshake and shifts each word out one bit per clock. A one-word holding register allows back-to-back words to stream with no idle bit between them, so the free-running downstream SIPO sees a continuous bitstream. Framing strobes mark the first and last bit of each word.

## Interface
- `WIDTH`, default 4: word width in bits; legal range is `WIDTH >= 2`.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: one clock; reset is synchronous and active-high.
- `in_data`, input, WIDTH: parallel word to serialize.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a word this cycle.
- `serial_out`, output, 1: serial bit; connects to SIPO `serial_in`.
- `serial_valid`, output, 1: `serial_out` carries a data bit this cycle.
- `frame_start`, output, 1: first bit of a word is on `serial_out`.
- `word_done`, output, 1: last bit of a word is on `serial_out`.
- `busy`, output, 1: a word is shifting or a word is held.

## Operation
- **State**
  - FSM states: IDLE and SHIFT.
  - Registers: `shift_reg[WIDTH-1:0]`, `bit_cnt` (`$clog2(WIDTH)` bits), `hold_reg[WIDTH-1:0]`, `hold_full`.
- **Handshake**
  - `in_ready = !rst && !hold_full`.
  - A word is accepted when `in_valid && in_ready` at a rising edge.
  - `in_data` is sampled only on accept.
  - `in_valid` may drop without being accepted; nothing is captured.
- **IDLE**
  - On accept: `shift_reg <= in_data`, `bit_cnt <= 0`, go to SHIFT.
  - Otherwise: stay in IDLE.
- **SHIFT, current bit**
  - Current bit is `shift_reg[WIDTH-1]` when `MSB_FIRST=1`, else `shift_reg[0]`.
- **SHIFT, not last bit** (`bit_cnt != WIDTH-1`)
  - Shift `shift_reg` toward the output end, filling with 0.
  - `bit_cnt` increments by 1.
  - An accept in this cycle writes `hold_reg <= in_data` and sets `hold_full <= 1`.
- **SHIFT, last bit** (`bit_cnt == WIDTH-1`), at the next edge:
  - If `hold_full`: `shift_reg <= hold_reg`, `hold_full <= 0`, `bit_cnt <= 0`, stay in SHIFT.
  - Else if accept this cycle (bypass): `shift_reg <= in_data`, `bit_cnt <= 0`, stay in SHIFT.
  - Else: go to IDLE.
- **Outputs** (all derived from registered state; no combinational path from `in_*` to serial outputs)
  - `serial_valid = (state == SHIFT)`.
  - `serial_out` = current bit when `serial_valid`, else 0.
  - `frame_start = serial_valid && bit_cnt == 0`.
  - `word_done = serial_valid && bit_cnt == WIDTH-1`.
  - `busy = (state == SHIFT) || hold_full`.
- **Reset**
  - State returns to IDLE; `shift_reg`, `hold_reg`, `bit_cnt` and `hold_full` clear to 0.
  - Reset asserted mid-word discards the in-flight word and any held word; there is no resume.
  - `rst` has priority over accept in the same cycle.

## Timing
- **Reset values** (during and after `rst`): `serial_out=0`, `serial_valid=0`, `frame_start=0`, `word_done=0`, `busy=0`. `in_ready=0` while `rst=1`, and 1 in the first cycle after `rst` falls.
- **Latency:** accept at edge N puts the first bit on `serial_out` in cycle N+1; the last bit appears in cycle N+WIDTH.
- **Throughput:** with `in_valid` held high, one word every `WIDTH` cycles with no gap cycles. `serial_valid` stays high continuously.
- **Backpressure:** `in_ready` drops the cycle after the hold register fills. It rises again the cycle after the held word moves into `shift_reg`.
- **Bypass:** a word presented first in the last-bit cycle with the hold register empty is accepted, and still streams with no gap.
- **Downstream alignment:** `WIDTH` cycles after `frame_start`, the same-clock SIPO's `parallel_out` equals the transmitted word. This holds when `MSB_FIRST=1` and the SIPO shifts toward its MSB.

## Test plan
All scenarios use `WIDTH=4` and `MSB_FIRST=1` unless stated otherwise.

1. **Reset:** hold `rst` high for 2 cycles with `in_valid=1` -> no accept, all outputs 0, `in_ready=0`. After release, `in_ready=1`, `busy=0`.
2. **Single word:** accept `4'b1011` at edge N -> `serial_out` is 1,0,1,1 in cycles N+1..N+4. `frame_start` high at N+1, `word_done` high at N+4, `serial_valid` low at N+5, state back to IDLE.
3. **Back-to-back:** `4'b1011` then `4'b0110` with `in_valid` held high -> the second word goes to the hold register at edge N+1 and `in_ready=0` for cycles N+2..N+4. Output is the 8 contiguous bits 10110110 with no gap. The attached SIPO shows `parallel_out=4'b0110` after the 8th bit.
4. **Bypass:** second word `4'b1100` presented only in the `word_done` cycle of the first word -> accepted immediately, with `frame_start` in the very next cycle and no gap.
5. **Reset mid-word:** assert `rst` during the 2nd bit of `4'b1011` while `4'b0101` is held -> the next cycle shows `serial_valid=0`, `busy=0`, `in_ready=0`. After release, neither word is transmitted.
6. **LSB first:** with `MSB_FIRST=0`, accept `4'b1011` -> `serial_out` is 1,1,0,1.
